dec_round_sched: RTL
====================

// Module: dec_round_sched
// PURPOSE
//  Round sequencer for the Modified AES-256 decryption path. Accepts one ciphertext block plus seed.
//  Drives the seed/round_num/data inputs of the invSbox + chacha20_prng datapath for rounds
//  NUM_ROUNDS..0 (descending) and feeds each round result back as the next round input.
//  Returns the final block over a valid/ready handshake. Sits between the decrypt top and invSbox.
// PARAMETERS
//  DATA_W     128  block width
//  SEED_W     256  PRNG seed width
//  RND_W      32   round_num width
//  NUM_ROUNDS 14   first (highest) round index; NUM_ROUNDS+1 rounds are applied, ending at round 0
//  PRNG_LAT   1    settle cycles allowed after round_num/sbox_in change before sbox_out is sampled (>=1)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       input block/seed offered
//  in_ready   out  1       scheduler can accept (high only in IDLE)
//  in_block   in   DATA_W  ciphertext block
//  in_seed    in   SEED_W  seed for this block
//  sbox_seed  out  SEED_W  to invSbox sbox_seed (latched seed)
//  round_num  out  RND_W   to invSbox round_num
//  sbox_in    out  DATA_W  to invSbox in (current state register)
//  sbox_out   in   DATA_W  from invSbox out
//  out_valid  out  1       out_block valid; held until accepted
//  out_ready  in   1       consumer accepts
//  out_block  out  DATA_W  decrypted block (= state register)
//  busy       out  1       high in WAIT or DONE
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high (clk, rst).
//  Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, round_num=0, sbox_seed=0,
//   state reg (sbox_in/out_block)=0, settle cnt=0. rst dominates every other input on the same edge.
//  FSM IDLE -> WAIT -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready edge: state reg<=in_block, sbox_seed<=in_seed,
//   round_num<=NUM_ROUNDS, cnt<=PRNG_LAT, go WAIT. in_valid with no accept: nothing latched.
//  WAIT: in_ready=0. cnt!=0: cnt<=cnt-1. cnt==0: state reg<=sbox_out (capture edge).
//   If round_num==0 go DONE, else round_num<=round_num-1 and cnt<=PRNG_LAT.
//   Each round = PRNG_LAT+1 cycles. round_num never wraps below 0.
//  DONE: out_valid=1, out_block stable, round_num held at 0.
//   out_valid&out_ready edge -> IDLE (in_ready rises next cycle; no same-cycle re-accept).
//   out_ready low: hold indefinitely; out_block must not change.
//  Latency: out_valid first high (NUM_ROUNDS+1)*(PRNG_LAT+1) edges after accept edge
//   (30 at defaults). Throughput: one block per latency+2 cycles minimum.
//  Inputs changing while not IDLE are ignored; sbox_seed held constant for the whole block.
//  rst mid-operation: immediate return to reset values; partial block discarded, no out_valid.
// CONFIGURATION
//  DEC_ABORT_EN defined: adds port abort (in,1). abort high on an edge in WAIT or DONE -> IDLE,
//   state reg/round_num/cnt cleared, out_valid low next cycle, no output produced.
//   abort in IDLE has no effect and does not block an accept on that edge; rst has priority.
//  Not defined: no abort port; a block always runs to DONE unless rst.
// STRUCTURE
//  Package dec_ctrl_pkg: state enum (S_IDLE, S_WAIT, S_DONE), DATA_W/SEED_W/RND_W defaults,
//   NUM_ROUNDS default 14.
//  Sub-module dec_settle_timer: loadable down-counter (load value PRNG_LAT, zero flag) used by WAIT.
//  invSbox/chacha20_prng are instantiated by the parent, not inside this block.
// TESTING
//  Bench model for invSbox: sbox_out = sbox_in ^ round_num (zero-extended), combinational.
//  1 Basic: in_block=0, seed=0 -> out_valid 30 cycles after accept, out_block=128'hF (XOR of 0..14);
//    round_num sequence 14,13..0 each held 2 cycles.
//  2 Backpressure: out_ready low 10 cycles in DONE -> out_valid/out_block stable; in_ready stays 0;
//    second in_valid ignored until IDLE.
//  3 Back-to-back: two blocks A=128'h1234, B=128'hFFFF with in_valid held -> outputs A^F, B^F in order,
//    no overlap, sbox_seed switches only at second accept.
//  4 Reset mid-run: rst at round_num=7 -> next cycle IDLE, in_ready=1, out_valid=0, round_num=0;
//    then new block completes normally.
//  5 PRNG_LAT=3 build: each round_num held 4 cycles; out_valid 60 cycles after accept, same result.
//  6 DEC_ABORT_EN: abort at round_num=5 -> IDLE next cycle, no out_valid; abort in DONE drops pending output.

Source files
------------

// File: rtl/dec_round_sched_pkg.sv
// Shared types and default widths for the decryption round scheduler.
package dec_ctrl_pkg;

  localparam int unsigned DATA_W          = 128;
  localparam int unsigned SEED_W          = 256;
  localparam int unsigned RND_W           = 32;
  localparam int unsigned NUM_ROUNDS_DFLT = 14;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/dec_round_sched_if.sv
// Upstream block/seed handshake, invSbox datapath hookup and downstream result handshake.
interface dec_round_sched_if;
  import dec_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_block;
  logic [SEED_W-1:0] in_seed;
  logic [SEED_W-1:0] sbox_seed;
  logic [RND_W-1:0]  round_num;
  logic [DATA_W-1:0] sbox_in;
  logic [DATA_W-1:0] sbox_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_block;
  logic              busy;

  // Scheduler side.
  modport master (
    input  in_valid, in_block, in_seed, sbox_out, out_ready,
    output in_ready, sbox_seed, round_num, sbox_in, out_valid, out_block, busy
  );

  // Environment side: producer, invSbox datapath and consumer.
  modport slave (
    output in_valid, in_block, in_seed, sbox_out, out_ready,
    input  in_ready, sbox_seed, round_num, sbox_in, out_valid, out_block, busy
  );

endinterface

// File: rtl/dec_settle_timer.sv
// Loadable down-counter giving the PRNG/invSbox path time to settle before each capture.
module dec_settle_timer #(
  parameter int unsigned LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int unsigned CntW = $clog2(LOAD_VAL + 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CntW'(LOAD_VAL);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dec_round_sched.sv
// Sequences rounds NUM_ROUNDS..0 through the external invSbox, feeding each result back.
// Optional DEC_ABORT_EN adds an abort input that drops the block in flight.
module dec_round_sched
  import dec_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DFLT,
  parameter int unsigned PRNG_LAT   = 1
) (
  input logic               clk,
  input logic               rst,
`ifdef DEC_ABORT_EN
  input logic               abort,
`endif
  dec_round_sched_if.master bus
);

  state_e            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic [RND_W-1:0]  r_round;
  logic [SEED_W-1:0] r_seed;
  logic [DATA_W-1:0] r_data;

  logic w_accept;
  logic w_cnt_zero;
  logic w_last_round;
  logic w_load;
  logic w_abort;

`ifdef DEC_ABORT_EN
  // Abort only acts on a block in flight; in IDLE it must not disturb an accept.
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept     = (r_state == S_IDLE) && bus.in_valid;
  assign w_last_round = (r_round == '0);
  assign w_load       = !w_abort &&
                        (w_accept || ((r_state == S_WAIT) && w_cnt_zero && !w_last_round));

  dec_settle_timer #(
    .LOAD_VAL (PRNG_LAT)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_abort),
    .i_load (w_load),
    .i_dec  (r_state == S_WAIT),
    .o_zero (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_round     <= '0;
      r_seed      <= '0;
      r_data      <= '0;
    end else if (w_abort) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_round     <= '0;
      r_data      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_WAIT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_data     <= bus.in_block;
            r_seed     <= bus.in_seed;
            r_round    <= RND_W'(NUM_ROUNDS);
          end
        end
        S_WAIT: begin
          if (w_cnt_zero) begin
            r_data <= bus.sbox_out;
            if (w_last_round) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_round <= r_round - 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.round_num = r_round;
  assign bus.sbox_seed = r_seed;
  assign bus.sbox_in   = r_data;
  assign bus.out_block = r_data;

endmodule
